// File: rtl/bram_ring_pkg.sv
// bram_ring_pkg: shared FSM state encoding and width-derivation helpers
// used by the ring writer and its staging FIFO.
package bram_ring_pkg;

   // Drain controller states.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_BLOCKED = 2'd2
   } state_t;

   // Bytes carried by one stream/BRAM word.
   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // Word-index width for a ring of the given depth.
   function automatic int addr_w(input int depth_words);
      return (depth_words > 1) ? $clog2(depth_words) : 1;
   endfunction

   // Occupancy width: must represent 0..depth inclusive.
   function automatic int count_w(input int fifo_depth);
      return $clog2(fifo_depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with full/empty/count.
// o_rdata always presents the head entry, so a pop can be registered
// downstream in the same cycle it is requested. i_clear empties the FIFO
// and overrides any push or pop in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 256
)(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_idx;
   logic [PW-1:0]    r_rd_idx;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_idx];
   assign w_do_push = i_push && !o_full && !i_clear;
   assign w_do_pop  = i_pop && !o_empty && !i_clear;

   // Storage array: data only, never reset.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_idx] <= i_wdata;
   end

   // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_idx <= r_wr_idx + PW'(1);
         if (w_do_pop)  r_rd_idx <= r_rd_idx + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bram_ring_writer.sv
// bram_ring_writer: stages a valid/ready word stream in a FIFO and drains
// it into a BRAM used as a circular buffer. In stop mode the writer never
// fills the slot just before the consumer's rd_ptr, so one slot stays free.
// Optional statistics (stall_cycles, fifo_hwm) are built only when the
// macro BRAM_RING_WRITER_STATS_EN is defined; otherwise they read as 0.
module bram_ring_writer
   import bram_ring_pkg::*;
#(
   parameter int DATA_WIDTH       = 64,
   parameter int BRAM_ADDR_WIDTH  = 16,
   parameter int BRAM_DEPTH_WORDS = 8192,
   parameter int FIFO_DEPTH       = 256
)(
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  enable,
   input  logic                                  stop_mode,
   input  logic                                  clear,
   input  logic [addr_w(BRAM_DEPTH_WORDS)-1:0]   rd_ptr,
   input  logic [DATA_WIDTH-1:0]                 s_data,
   input  logic                                  s_last,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   output logic                                  bram_clk,
   output logic                                  bram_rst,
   output logic [BRAM_ADDR_WIDTH-1:0]            bram_addr,
   output logic [DATA_WIDTH-1:0]                 bram_din,
   output logic                                  bram_en,
   output logic [DATA_WIDTH/8-1:0]               bram_we,
   output logic [count_w(FIFO_DEPTH)-1:0]        fifo_count,
   output logic [addr_w(BRAM_DEPTH_WORDS)-1:0]   wr_ptr,
   output logic [addr_w(BRAM_DEPTH_WORDS)-1:0]   commit_ptr,
   output logic [31:0]                           wrap_count,
   output logic [31:0]                           stall_cycles,
   output logic [count_w(FIFO_DEPTH)-1:0]        fifo_hwm
);

   localparam int BYTES = bytes_per_word(DATA_WIDTH);
   localparam int AW    = addr_w(BRAM_DEPTH_WORDS);
   localparam int CW    = count_w(FIFO_DEPTH);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_ready_en;
   logic                  r_bram_vld;
   logic                  r_bram_last;
   logic [DATA_WIDTH-1:0] r_bram_din;
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_commit_ptr;
   logic [31:0]           r_wrap_count;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [CW-1:0]         w_fifo_count;
   logic [DATA_WIDTH:0]   w_fifo_rdata;
   logic [AW-1:0]         w_slot_nxt;
   logic                  w_ring_full;
   logic                  w_wr_fire;

   // s_ready stays low until the first edge after reset release.
   assign s_ready  = r_ready_en && !w_fifo_full && !clear;
   assign w_push   = s_valid && s_ready;
   assign bram_clk = clk;
   assign bram_rst = ~rstn;

   sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_clear (clear),
      .i_push  (w_push),
      .i_wdata ({s_last, s_data}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // Slot the next popped word would land in: one past wr_ptr when a write
   // is already on the port this cycle. Blocking on that slot keeps the
   // in-flight word from ever landing on rd_ptr-1.
   assign w_slot_nxt  = r_wr_ptr + AW'(r_bram_vld);
   assign w_ring_full = stop_mode && ((w_slot_nxt + AW'(1)) == rd_ptr);

   // Ready gate: rises on the first clock edge after reset release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_ready_en <= 1'b0;
      else       r_ready_en <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next state; a word is popped in every cycle heading into WRITE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (enable && !w_fifo_empty && !w_ring_full) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (!enable || w_fifo_empty) w_state_nxt = S_IDLE;
            else if (w_ring_full)        w_state_nxt = S_BLOCKED;
         end
         S_BLOCKED: begin
            if (!enable || w_fifo_empty) w_state_nxt = S_IDLE;
            else if (!w_ring_full)       w_state_nxt = S_WRITE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear) w_state_nxt = S_IDLE;
   end

   assign w_pop = (w_state_nxt == S_WRITE);

   // Output register: popped word is presented on the BRAM port next cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bram_vld  <= 1'b0;
         r_bram_last <= 1'b0;
         r_bram_din  <= '0;
      end else begin
         r_bram_vld <= w_pop && !clear;
         if (w_pop) begin
            r_bram_last <= w_fifo_rdata[DATA_WIDTH];
            r_bram_din  <= w_fifo_rdata[DATA_WIDTH-1:0];
         end
      end
   end

   // clear cancels a write already sitting on the port this cycle.
   assign w_wr_fire = r_bram_vld && !clear;

   // Ring pointers: advance per completed write, commit on packet end.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_wrap_count <= '0;
      end else if (clear) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_wrap_count <= '0;
      end else if (w_wr_fire) begin
         r_wr_ptr <= r_wr_ptr + AW'(1);
         if (r_bram_last)              r_commit_ptr <= r_wr_ptr + AW'(1);
         if (r_wr_ptr == {AW{1'b1}})   r_wrap_count <= r_wrap_count + 32'd1;
      end
   end

   assign bram_en    = w_wr_fire;
   assign bram_we    = {BYTES{w_wr_fire}};
   assign bram_din   = r_bram_din;
   assign bram_addr  = BRAM_ADDR_WIDTH'(r_wr_ptr) * BRAM_ADDR_WIDTH'(BYTES);
   assign fifo_count = w_fifo_count;
   assign wr_ptr     = r_wr_ptr;
   assign commit_ptr = r_commit_ptr;
   assign wrap_count = r_wrap_count;

`ifdef BRAM_RING_WRITER_STATS_EN
   logic [31:0]   r_stall_cycles;
   logic [CW-1:0] r_fifo_hwm;
   logic          w_stall_evt;

   assign w_stall_evt = (s_valid && !s_ready) || (r_state == S_BLOCKED);

   // Saturating stall counter and occupancy high-water mark.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cycles <= '0;
         r_fifo_hwm     <= '0;
      end else if (clear) begin
         r_stall_cycles <= '0;
         r_fifo_hwm     <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_fifo_count > r_fifo_hwm)
            r_fifo_hwm <= w_fifo_count;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign fifo_hwm     = r_fifo_hwm;
`else
   assign stall_cycles = '0;
   assign fifo_hwm     = '0;
`endif

endmodule

// File: tb/tb_bram_ring_writer.sv
// tb_bram_ring_writer: randomized-data bench for bram_ring_writer with a
// 16-word ring and 256-entry FIFO. A queue-based ring model predicts every
// BRAM write (address, data), pointers and wrap count.
module tb_bram_ring_writer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic        stop_mode = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  rd_ptr = '0;
   logic [63:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        bram_clk;
   logic        bram_rst;
   logic [15:0] bram_addr;
   logic [63:0] bram_din;
   logic        bram_en;
   logic [7:0]  bram_we;
   logic [8:0]  fifo_count;
   logic [3:0]  wr_ptr;
   logic [3:0]  commit_ptr;
   logic [31:0] wrap_count;
   logic [31:0] stall_cycles;
   logic [8:0]  fifo_hwm;

   bram_ring_writer #(
      .DATA_WIDTH       (64),
      .BRAM_ADDR_WIDTH  (16),
      .BRAM_DEPTH_WORDS (DEPTH),
      .FIFO_DEPTH       (256)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .enable       (enable),
      .stop_mode    (stop_mode),
      .clear        (clear),
      .rd_ptr       (rd_ptr),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .bram_clk     (bram_clk),
      .bram_rst     (bram_rst),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .fifo_count   (fifo_count),
      .wr_ptr       (wr_ptr),
      .commit_ptr   (commit_ptr),
      .wrap_count   (wrap_count),
      .stall_cycles (stall_cycles),
      .fifo_hwm     (fifo_hwm)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state.
   logic [63:0] m_q[$];
   bit          m_lq[$];
   int          m_wr = 0;
   int          m_commit = 0;
   int          m_wrap = 0;
   logic [15:0] e_addr[$];
   logic [63:0] e_data[$];

   // Observed BRAM writes.
   logic [15:0] o_addr[$];
   logic [63:0] o_data[$];
   int          o_cyc[$];
   logic [63:0] lmem [DEPTH];
   logic [63:0] pw[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor, sampled mid-cycle after bench drives settle.
   always begin
      @(negedge clk);
      #2;
      if (bram_en === 1'b1) begin
         o_addr.push_back(bram_addr);
         o_data.push_back(bram_din);
         o_cyc.push_back(cyc);
         lmem[bram_addr[6:3]] = bram_din;
         if (bram_we !== 8'hFF) check_eq("we_all_ones", bram_we, 64'hFF);
      end
   end

   // Ring rule: word k of the stream lands at slot k mod DEPTH; in stop mode
   // nothing may be written at rd_ptr-1.
   task automatic model_drain(input int rd, input bit stopm);
      logic [63:0] d;
      bit          l;
      while (m_q.size() > 0 && !(stopm && ((m_wr + 1) % DEPTH) == rd)) begin
         d = m_q.pop_front();
         l = m_lq.pop_front();
         e_addr.push_back(16'(m_wr * 8));
         e_data.push_back(d);
         m_wr = (m_wr + 1) % DEPTH;
         if (l) m_commit = m_wr;
         if (m_wr == 0) m_wrap++;
      end
   endtask

   task automatic model_reset();
      m_q.delete(); m_lq.delete(); pw.delete();
      m_wr = 0; m_commit = 0; m_wrap = 0;
      e_addr.delete(); e_data.delete();
      o_addr.delete(); o_data.delete(); o_cyc.delete();
   endtask

   task automatic compare_writes(input string tag);
      check_eq({tag, "_nwr"}, 64'(o_addr.size()), 64'(e_addr.size()));
      for (int i = 0; i < o_addr.size() && i < e_addr.size(); i++) begin
         check_eq({tag, "_addr"}, o_addr[i], e_addr[i]);
         check_eq({tag, "_data"}, o_data[i], e_data[i]);
      end
      check_eq({tag, "_wr_ptr"}, wr_ptr, 64'(m_wr));
      check_eq({tag, "_commit"}, commit_ptr, 64'(m_commit));
      check_eq({tag, "_wrap"}, wrap_count, 64'(m_wrap));
      e_addr.delete(); e_data.delete();
      o_addr.delete(); o_data.delete(); o_cyc.delete();
   endtask

   // Present one word from a negedge until accepted; returns acceptance cycle.
   task automatic push(input logic [63:0] d, input logic l, output int acc);
      bit ok;
      ok = 0; acc = -1;
      s_data = d; s_last = l; s_valid = 1'b1;
      for (int k = 0; k < 400 && !ok; k++) begin
         #1;
         ok = s_ready;
         if (ok) acc = cyc;
         @(negedge clk);
      end
      s_valid = 1'b0;
      if (!ok) check_eq("push_accept", 0, 1);
      else begin
         m_q.push_back(d); m_lq.push_back(l); pw.push_back(d);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
   endtask

   task automatic push_burst(input int n, input bit gaps, input bit last_at_end);
      int acc;
      logic [63:0] d;
      for (int i = 0; i < n; i++) begin
         d = {$urandom, $urandom};
         push(d, (last_at_end && i == n - 1) || ($urandom_range(0, 3) == 0), acc);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, acc, exp_stall, exp_hwm, accepted, n_before;
      bit found;
`ifdef BRAM_RING_WRITER_STATS_EN
      exp_stall = 44; exp_hwm = 256;
`else
      exp_stall = 0;  exp_hwm = 0;
`endif

      // ---- reset state ----
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_s_ready", s_ready, 0);
      check_eq("rst_bram_en", bram_en, 0);
      check_eq("rst_bram_rst", bram_rst, 1);
      check_eq("rst_bram_we", bram_we, 0);
      check_eq("rst_addr", bram_addr, 0);
      check_eq("rst_din", bram_din, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_wr_ptr", wr_ptr, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_eq("ready_before_edge", s_ready, 0);
      @(negedge clk);
      #1;
      check_eq("ready_after_edge", s_ready, 1);
      check_eq("bram_rst_released", bram_rst, 0);
      @(negedge clk);

      // ---- three-word packet, latency and addresses ----
      enable = 1'b1;
      push({$urandom, $urandom}, 1'b0, c0);
      push({$urandom, $urandom}, 1'b0, acc);
      push({$urandom, $urandom}, 1'b1, acc);
      repeat (10) @(negedge clk);
      if (o_cyc.size() > 0) check_eq("latency", 64'(o_cyc[0] - c0), 2);
      else                  check_eq("latency_nowrite", 0, 1);
      if (o_cyc.size() > 2) check_eq("back_to_back", 64'(o_cyc[2] - o_cyc[0]), 2);
      model_drain(0, 0);
      compare_writes("pkt3");

      // ---- overwrite mode: 20 words wrap the 16-word ring ----
      do_clear();
      push_burst(20, 1, 1);
      repeat (20) @(negedge clk);
      model_drain(0, 0);
      compare_writes("ovw");
      check_eq("ovw_slot0_word16", lmem[0], pw[16]);
      check_eq("ovw_wr_ptr4", wr_ptr, 4);
      check_eq("ovw_wrap1", wrap_count, 1);

      // ---- stop mode: block one slot before rd_ptr, then release ----
      do_clear();
      stop_mode = 1'b1; rd_ptr = 4'd0;
      push_burst(20, 1, 1);
      repeat (30) @(negedge clk);
      model_drain(0, 1);
      compare_writes("stop_a");
      check_eq("stop_a_count", fifo_count, 5);
      rd_ptr = 4'd5;
      repeat (20) @(negedge clk);
      model_drain(5, 1);
      compare_writes("stop_b");
      check_eq("stop_b_wr_ptr4", wr_ptr, 4);
      check_eq("stop_b_count", fifo_count, 0);
      stop_mode = 1'b0; rd_ptr = 4'd0;

      // ---- enable low: 300 offered cycles fill FIFO to 256 ----
      enable = 1'b0;
      do_clear();
      accepted = 0;
      s_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         s_data = {$urandom, $urandom};
         s_last = ($urandom_range(0, 7) == 0);
         #1;
         if (s_ready) begin
            accepted++;
            m_q.push_back(s_data); m_lq.push_back(s_last); pw.push_back(s_data);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("fill_accepted", 64'(accepted), 256);
      check_eq("fill_count", fifo_count, 256);
      check_eq("fill_ready_low", s_ready, 0);
      check_eq("fill_no_writes", 64'(o_addr.size()), 0);
      check_eq("fill_stall", stall_cycles, 64'(exp_stall));
      check_eq("fill_hwm", fifo_hwm, 64'(exp_hwm));
      enable = 1'b1;
      repeat (280) @(negedge clk);
      model_drain(0, 0);
      compare_writes("drain256");
      check_eq("drain_count", fifo_count, 0);

      // ---- clear mid-packet with 10 words queued ----
      enable = 1'b0;
      do_clear();
      push_burst(10, 0, 0);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      clear = 1'b1;
      #1;
      check_eq("clr_cancels_en", bram_en, 0);
      @(negedge clk);
      clear = 1'b0;
      #1;
      check_eq("clr_count", fifo_count, 0);
      check_eq("clr_wr_ptr", wr_ptr, 0);
      check_eq("clr_commit", commit_ptr, 0);
      check_eq("clr_wrap", wrap_count, 0);
      n_before = o_addr.size();
      for (int i = 0; i < o_addr.size(); i++) begin
         check_eq("clr_pre_addr", o_addr[i], 64'(i * 8));
         check_eq("clr_pre_data", o_data[i], pw[i]);
      end
      repeat (20) @(negedge clk);
      check_eq("clr_no_more_writes", 64'(o_addr.size()), 64'(n_before));

      // ---- asynchronous reset while a write is on the port ----
      enable = 1'b0;
      do_clear();
      push_burst(10, 0, 0);
      enable = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         #1;
         found = bram_en;
      end
      check_eq("arst_write_seen", 64'(found), 1);
      rstn = 1'b0;
      #1;
      check_eq("arst_bram_en", bram_en, 0);
      check_eq("arst_we", bram_we, 0);
      check_eq("arst_addr", bram_addr, 0);
      check_eq("arst_din", bram_din, 0);
      check_eq("arst_wr_ptr", wr_ptr, 0);
      check_eq("arst_commit", commit_ptr, 0);
      check_eq("arst_count", fifo_count, 0);
      check_eq("arst_s_ready", s_ready, 0);
      check_eq("arst_bram_rst", bram_rst, 1);
      check_eq("arst_stall", stall_cycles, 0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
